// File: rtl/mem_wb_writeback_pkg.sv
// Shared definitions for the MEM/WB writeback stage: memop codes, FSM states, default widths.
package mem_wb_writeback_pkg;

    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_REG_AW  = 5;
    localparam int unsigned WB_TIMEOUT = 256;

    localparam logic [2:0] MEMOP_NONE = 3'd0;
    localparam logic [2:0] MEMOP_LB   = 3'd1;
    localparam logic [2:0] MEMOP_LBU  = 3'd2;
    localparam logic [2:0] MEMOP_LH   = 3'd3;
    localparam logic [2:0] MEMOP_LHU  = 3'd4;
    localparam logic [2:0] MEMOP_LW   = 3'd5;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WAIT  = 2'd1,
        WB_WRITE = 2'd2
    } wb_state_e;

    // Codes 6-7 are reserved and behave like MEMOP_NONE.
    function automatic logic is_load(input logic [2:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LW);
    endfunction

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Big-endian load extraction and alignment check; purely combinational so store logic can reuse it.
module mem_wb_writeback_load_align
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic [2:0]        op,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_h;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Shift the selected lane to the top so byte 0 / half 0 are the MSBs.
    assign sh_b     = word << {off, 3'b000};
    assign sh_h     = word << {off[1], 4'b0000};
    assign byte_sel = sh_b[DATA_W-1 -: 8];
    assign half_sel = sh_h[DATA_W-1 -: 16];

    always_comb begin
        data     = word;
        misalign = 1'b0;
        case (op)
            MEMOP_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            MEMOP_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            MEMOP_LH: begin
                data     = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misalign = off[0];
            end
            MEMOP_LHU: begin
                data     = {{(DATA_W-16){1'b0}}, half_sel};
                misalign = off[0];
            end
            MEMOP_LW:  misalign = (off != 2'b00);
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB stage: issues data-memory reads for loads, aligns load data and drives the register file write port.
module mem_wb_writeback
    import mem_wb_writeback_pkg::*;
#(
    parameter int unsigned DATA_W  = WB_DATA_W,
    parameter int unsigned REG_AW  = WB_REG_AW,
    parameter int unsigned TIMEOUT = WB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wreg,
    input  logic [REG_AW-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [2:0]        in_memop,
    input  logic [DATA_W-1:0] in_maddr,
    output logic              dmem_req,
    output logic [DATA_W-1:0] dmem_addr,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              stall_req,
    output logic              exc_align,
    output logic              exc_bus,
    output logic [DATA_W-1:0] exc_addr
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    wb_state_e         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              lat_wreg, lat_wreg_n;
    logic [REG_AW-1:0] lat_waddr, lat_waddr_n;
    logic [2:0]        lat_op, lat_op_n;
    logic [DATA_W-1:0] lat_addr, lat_addr_n;

    logic              we_n, req_n, exc_align_n, exc_bus_n;
    logic [REG_AW-1:0] waddr_n;
    logic [DATA_W-1:0] wdata_n, dmem_addr_n, exc_addr_n;

    logic              accept;
    logic              in_is_load;
    logic [2:0]        al_op;
    logic [1:0]        al_off;
    logic [DATA_W-1:0] al_data;
    logic              al_misalign;

    assign in_ready   = (state == WB_IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign in_is_load = is_load(in_memop);
    assign stall_req  = (state != WB_IDLE) || (accept && in_is_load);

    // One aligner: checks the incoming op in IDLE, extracts the latched op otherwise.
    assign al_op  = (state == WB_IDLE) ? in_memop : lat_op;
    assign al_off = (state == WB_IDLE) ? in_maddr[1:0] : lat_addr[1:0];

    mem_wb_writeback_load_align #(.DATA_W(DATA_W)) u_align (
        .op       (al_op),
        .off      (al_off),
        .word     (dmem_rdata),
        .data     (al_data),
        .misalign (al_misalign)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_wreg_n  = lat_wreg;
        lat_waddr_n = lat_waddr;
        lat_op_n    = lat_op;
        lat_addr_n  = lat_addr;
        we_n        = 1'b0;
        req_n       = 1'b0;
        exc_align_n = 1'b0;
        exc_bus_n   = 1'b0;
        waddr_n     = waddr;
        wdata_n     = wdata;
        dmem_addr_n = dmem_addr;
        exc_addr_n  = exc_addr;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    if (!in_is_load) begin
                        we_n    = in_wreg && (in_waddr != '0);
                        waddr_n = in_waddr;
                        wdata_n = in_wdata;
                    end else if (al_misalign) begin
                        exc_align_n = 1'b1;
                        exc_addr_n  = in_maddr;
                    end else begin
                        req_n       = 1'b1;
                        dmem_addr_n = {in_maddr[DATA_W-1:2], 2'b00};
                        lat_wreg_n  = in_wreg;
                        lat_waddr_n = in_waddr;
                        lat_op_n    = in_memop;
                        lat_addr_n  = in_maddr;
                        cnt_n       = '0;
                        state_n     = WB_WAIT;
                    end
                end
            end
            WB_WAIT: begin
                req_n = 1'b1;
                if (dmem_ack) begin
                    req_n   = 1'b0;
                    we_n    = lat_wreg && (lat_waddr != '0);
                    waddr_n = lat_waddr;
                    wdata_n = al_data;
                    state_n = WB_WRITE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    req_n      = 1'b0;
                    exc_bus_n  = 1'b1;
                    exc_addr_n = lat_addr;
                    state_n    = WB_IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WB_WRITE: state_n = WB_IDLE;
            default:  state_n = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WB_IDLE;
            cnt       <= '0;
            lat_wreg  <= 1'b0;
            lat_waddr <= '0;
            lat_op    <= MEMOP_NONE;
            lat_addr  <= '0;
            we        <= 1'b0;
            dmem_req  <= 1'b0;
            exc_align <= 1'b0;
            exc_bus   <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            dmem_addr <= '0;
            exc_addr  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_wreg  <= lat_wreg_n;
            lat_waddr <= lat_waddr_n;
            lat_op    <= lat_op_n;
            lat_addr  <= lat_addr_n;
            we        <= we_n;
            dmem_req  <= req_n;
            exc_align <= exc_align_n;
            exc_bus   <= exc_bus_n;
            waddr     <= waddr_n;
            wdata     <= wdata_n;
            dmem_addr <= dmem_addr_n;
            exc_addr  <= exc_addr_n;
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: ALU stream, extracting loads, misalignment, bus timeout, reset mid-load.
module tb_mem_wb_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wreg;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic [2:0]  in_memop;
    logic [31:0] in_maddr;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall_req;
    logic        exc_align;
    logic        exc_bus;
    logic [31:0] exc_addr;

    int vectors = 0;
    int miscompares = 0;

    mem_wb_writeback #(.DATA_W(32), .REG_AW(5), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wreg    (in_wreg),
        .in_waddr   (in_waddr),
        .in_wdata   (in_wdata),
        .in_memop   (in_memop),
        .in_maddr   (in_maddr),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .stall_req  (stall_req),
        .exc_align  (exc_align),
        .exc_bus    (exc_bus),
        .exc_addr   (exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic wreg, input logic [4:0] ra,
                         input logic [31:0] wd, input logic [31:0] ma);
        in_valid = 1'b1;
        in_memop = op;
        in_wreg  = wreg;
        in_waddr = ra;
        in_wdata = wd;
        in_maddr = ma;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_wreg = 1'b0; in_waddr = '0; in_wdata = '0;
        in_memop = 3'd0; in_maddr = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        step();
        step();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_daddr", dmem_addr, 32'd0);
        chk("rst_exc", {30'd0, exc_align, exc_bus}, 32'd0);
        chk("rst_excaddr", exc_addr, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_stall", 32'(stall_req), 32'd0);

        // Back-to-back ALU results: r3, r4, then r0 which must not write.
        drive(3'd0, 1'b1, 5'd3, 32'h11, 32'h0);
        step();
        chk("alu_r3_we", 32'(we), 32'd1);
        chk("alu_r3_waddr", 32'(waddr), 32'd3);
        chk("alu_r3_wdata", wdata, 32'h11);
        drive(3'd0, 1'b1, 5'd4, 32'h22, 32'h0);
        step();
        chk("alu_r4_we", 32'(we), 32'd1);
        chk("alu_r4_waddr", 32'(waddr), 32'd4);
        chk("alu_r4_wdata", wdata, 32'h22);
        drive(3'd0, 1'b1, 5'd0, 32'h33, 32'h0);
        step();
        chk("alu_r0_we", 32'(we), 32'd0);
        in_valid = 1'b0;
        dmem_ack = 1'b1;
        step();
        chk("idle_we", 32'(we), 32'd0);
        chk("unsol_ack_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;

        // LB 0x1003 on word 0x801122F0, ack in the third wait cycle.
        drive(3'd1, 1'b1, 5'd5, 32'h0, 32'h1003);
        #1;
        chk("lb_stall_accept", 32'(stall_req), 32'd1);
        step();
        in_valid = 1'b0;
        chk("lb_req", 32'(dmem_req), 32'd1);
        chk("lb_daddr", dmem_addr, 32'h1000);
        chk("lb_ready", 32'(in_ready), 32'd0);
        chk("lb_stall_w0", 32'(stall_req), 32'd1);
        step();
        chk("lb_req_w1", 32'(dmem_req), 32'd1);
        step();
        chk("lb_req_w2", 32'(dmem_req), 32'd1);
        chk("lb_stall_w2", 32'(stall_req), 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h8011_22F0;
        step();
        dmem_ack = 1'b0;
        chk("lb_we", 32'(we), 32'd1);
        chk("lb_waddr", 32'(waddr), 32'd5);
        chk("lb_wdata", wdata, 32'hFFFF_FFF0);
        chk("lb_req_off", 32'(dmem_req), 32'd0);
        chk("lb_write_ready", 32'(in_ready), 32'd0);
        chk("lb_write_stall", 32'(stall_req), 32'd1);
        step();
        chk("lb_done_we", 32'(we), 32'd0);
        chk("lb_done_ready", 32'(in_ready), 32'd1);

        // LHU 0x2002 with ack in the first request cycle.
        drive(3'd4, 1'b1, 5'd6, 32'h0, 32'h2002);
        step();
        in_valid = 1'b0;
        chk("lhu_daddr", dmem_addr, 32'h2000);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234_ABCD;
        step();
        dmem_ack = 1'b0;
        chk("lhu_we", 32'(we), 32'd1);
        chk("lhu_wdata", wdata, 32'h0000_ABCD);
        step();

        // LH same address: sign-extended.
        drive(3'd3, 1'b1, 5'd6, 32'h0, 32'h2002);
        step();
        in_valid = 1'b0;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("lh_we", 32'(we), 32'd1);
        chk("lh_wdata", wdata, 32'hFFFF_ABCD);
        step();

        // Misaligned LW.
        drive(3'd5, 1'b1, 5'd7, 32'h0, 32'h3001);
        step();
        in_valid = 1'b0;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_exc", 32'(exc_align), 32'd1);
        chk("mis_addr", exc_addr, 32'h3001);
        chk("mis_we", 32'(we), 32'd0);
        chk("mis_ready", 32'(in_ready), 32'd1);
        step();
        chk("mis_pulse_end", 32'(exc_align), 32'd0);

        // LW 0x4000 that never gets an ack.
        drive(3'd5, 1'b1, 5'd7, 32'h0, 32'h4000);
        step();
        in_valid = 1'b0;
        chk("to_req_c0", 32'(dmem_req), 32'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_req_hold", 32'(dmem_req), 32'd1);
        end
        step();
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_exc_bus", 32'(exc_bus), 32'd1);
        chk("to_exc_addr", exc_addr, 32'h4000);
        chk("to_we", 32'(we), 32'd0);
        chk("to_ready", 32'(in_ready), 32'd1);
        step();
        chk("to_pulse_end", 32'(exc_bus), 32'd0);

        // Same load, ack arrives in the final allowed cycle.
        drive(3'd5, 1'b1, 5'd7, 32'h0, 32'h4000);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) step();
        chk("late_req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_BABE;
        step();
        dmem_ack = 1'b0;
        chk("late_we", 32'(we), 32'd1);
        chk("late_waddr", 32'(waddr), 32'd7);
        chk("late_wdata", wdata, 32'hCAFE_BABE);
        chk("late_no_bus", 32'(exc_bus), 32'd0);
        step();

        // Reset during WAIT, stale ack afterwards.
        drive(3'd5, 1'b1, 5'd8, 32'h0, 32'h5000);
        step();
        in_valid = 1'b0;
        chk("rstmid_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        step();
        chk("rstmid_req_drop", 32'(dmem_req), 32'd0);
        chk("rstmid_ready_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        step();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        chk("rstmid_we", 32'(we), 32'd0);
        chk("rstmid_req_idle", 32'(dmem_req), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd1);
        step();
        chk("rstmid_we2", 32'(we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- Last pipeline stage of the five-stage MIPS32 flow CPU. It is the producer that drives the register file's write port (we/waddr/wdata).
- Accepts retiring instructions from the EX/MEM stage and issues data-memory reads for loads through a req/ack handshake.
- Byte- and half-word-aligns and extends load data, then commits one register write per instruction.
- Raises a stall request to pipeline control while a load is outstanding, and flags alignment and bus-timeout errors.

Parameters:
- DATA_W, 32, data/register width (matches `RegBus`).
- REG_AW, 5, register address width (matches `RegAddrBus`).
- TIMEOUT, 256, maximum cycles to wait for dmem_ack before aborting the load.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (`RESTABLE` = 1)
- in_valid  in  1  EX/MEM presents a retiring instruction
- in_ready  out  1  stage can accept this cycle
- in_wreg  in  1  instruction writes a GPR
- in_waddr  in  REG_AW  destination GPR
- in_wdata  in  DATA_W  ALU result (non-load)
- in_memop  in  3  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5; 6-7 are treated as NONE
- in_maddr  in  DATA_W  load byte address
- dmem_req  out  1  read request
- dmem_addr  out  DATA_W  word-aligned address ({in_maddr[31:2],2'b00})
- dmem_ack  in  1  read data valid this cycle
- dmem_rdata  in  DATA_W  read word, big-endian (byte 0 = [31:24])
- we  out  1  register file write enable
- waddr  out  REG_AW  register file write address
- wdata  out  DATA_W  register file write data
- stall_req  out  1  hold upstream stages
- exc_align  out  1  one-cycle pulse: misaligned load
- exc_bus  out  1  one-cycle pulse: load timed out
- exc_addr  out  DATA_W  offending address, valid with either exception pulse

Behaviour:
- Reset values (synchronous, rst=1): state=IDLE; we, dmem_req, exc_align, exc_bus = 0; waddr, wdata, dmem_addr, exc_addr = 0; wait counter = 0.
- in_ready = (state==IDLE) && !rst. stall_req = (state!=IDLE) || (accepted op is a load this cycle).
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE, accept non-load:
  - Next cycle: we = in_wreg && (in_waddr!=0), waddr/wdata registered from inputs.
  - Latency 1; throughput 1 per cycle; state stays IDLE.
  - When nothing is accepted, we=0 next cycle.
- IDLE, accept load, aligned:
  - LB/LBU: any address. LH/LHU: maddr[0]=0. LW: maddr[1:0]=0.
  - Next cycle: dmem_req=1, dmem_addr registered, state -> WAIT_MEM.
  - Latch waddr, wreg, op, and maddr[1:0]. Clear the counter.
- IDLE, accept load, misaligned:
  - No memory access. Next cycle: exc_align=1, exc_addr=in_maddr, we=0; state stays IDLE.
- WAIT_MEM:
  - dmem_req and dmem_addr held stable until ack. The counter increments each cycle without ack.
  - On dmem_ack:
    - dmem_req=0 in the following cycle.
    - Capture the extracted value and go to WRITE.
    - dmem_ack in the same cycle the request first asserts is legal.
  - When the counter reaches TIMEOUT-1 with no ack: next cycle dmem_req=0, exc_bus=1, exc_addr=latched address, no write, state -> IDLE.
  - An ack arriving in that same cycle wins (normal completion).
- Load extraction (big-endian):
  - LB/LBU select byte maddr[1:0] (0 = bits [31:24]).
  - LH/LHU select half maddr[1] (0 = bits [31:16]).
  - LB and LH sign-extend to DATA_W; LBU and LHU zero-extend.
- WRITE: single cycle. we = latched wreg && (waddr!=0), wdata = extracted value; -> IDLE. in_ready stays 0 this cycle.
- Unsolicited dmem_ack in IDLE or WRITE is ignored.
- Reset mid-load: dmem_req drops the cycle after rst; a later stale ack is ignored.
- At most one we=1 per retired instruction; we is never asserted with waddr=0.

Decomposition:
- defines.vh (shared) gains:
  - memop codes (`MEMOP_NONE`..`MEMOP_LW`)
  - FSM state encodings (`WB_IDLE`, `WB_WAIT`, `WB_WRITE`)
  - `WB_TIMEOUT` default
- Reuse existing `RegBus`, `RegAddrBus`, `RESTABLE`, `WRITEABLE`, `ZEROWORD`.
- One combinational sub-module, load_align (op, addr[1:0], word -> aligned/extended data and misalign flag), shared with future store logic.

Test Plan:
- Non-load stream: back-to-back valid ALU ops writing r3=0x11, r4=0x22, r0=0x33 -> we pulses on consecutive cycles for r3 and r4, wdata matches; the r0 write is suppressed (we=0).
- LB at 0x1003, memory word 0x8011_22F0, ack after 3 cycles:
  - dmem_addr=0x1000; stall_req high throughout.
  - wdata=0xFFFF_FFF0 to the target register one cycle after ack.
- LHU at 0x2002, word 0x1234_ABCD, ack same cycle as req -> wdata=0x0000_ABCD; LH same address -> 0xFFFF_ABCD.
- LW at 0x3001 -> no dmem_req, exc_align=1 for one cycle, exc_addr=0x3001, we=0, in_ready high next cycle.
- LW at 0x4000 with TIMEOUT=8 and no ack:
  - dmem_req held 8 cycles, then exc_bus=1 and exc_addr=0x4000, no write.
  - Second case: ack in the final cycle -> normal write, no exc_bus.
- rst asserted during WAIT_MEM, ack two cycles later -> dmem_req=0 after rst, we never asserts, state IDLE.
